// File: rtl/tl_buffer_ad.sv
// TileLink-UL A/D buffer: two independent circular FIFOs, 1-cycle latency, ready = not full (no comb ready path).
// Optional TL_BUFFER_FLOW_EN: an empty FIFO forwards its input combinationally (0-cycle latency).

module tl_buffer_ad_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_vld,
  output logic         in_rdy,
  input  logic [W-1:0] in_dat,
  output logic         out_vld,
  input  logic         out_rdy,
  output logic [W-1:0] out_dat,
  output logic [3:0]   count
);
  localparam int            PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);
  localparam logic [3:0]    FULL = 4'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [W-1:0]  mem_d [DEPTH];
  logic [PW-1:0] rptr_q, rptr_d;
  logic [PW-1:0] wptr_q, wptr_d;
  logic [3:0]    count_q, count_d;
  logic          empty, enq, deq;

  assign empty  = (count_q == 4'd0);
  assign in_rdy = !reset && (count_q != FULL);
  assign count  = count_q;

  always_comb begin
    out_vld = !empty;
    out_dat = mem_q[rptr_q];
    enq     = in_vld && in_rdy;
`ifdef TL_BUFFER_FLOW_EN
    // Bypass only while empty; a beat taken downstream this cycle is never stored.
    if (empty && !reset) begin
      out_vld = in_vld;
      out_dat = in_dat;
      enq     = in_vld && in_rdy && !out_rdy;
    end
`endif
    deq = out_rdy && !empty;
  end

  always_comb begin
    mem_d   = mem_q;
    rptr_d  = rptr_q;
    wptr_d  = wptr_q;
    count_d = count_q;
    if (enq) begin
      mem_d[wptr_q] = in_dat;
      wptr_d        = (wptr_q == LAST) ? '0 : wptr_q + 1'b1;
    end
    if (deq) begin
      rptr_d = (rptr_q == LAST) ? '0 : rptr_q + 1'b1;
    end
    case ({enq, deq})
      2'b10:   count_d = count_q + 4'd1;
      2'b01:   count_d = count_q - 4'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
    end
  end
endmodule

module tl_buffer_ad #(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2
) (
  input  logic        clock,
  input  logic        reset,
  output logic        auto_in_a_ready,
  input  logic        auto_in_a_valid,
  input  logic [2:0]  auto_in_a_bits_opcode,
  input  logic [2:0]  auto_in_a_bits_param,
  input  logic [2:0]  auto_in_a_bits_size,
  input  logic [2:0]  auto_in_a_bits_source,
  input  logic [30:0] auto_in_a_bits_address,
  input  logic [7:0]  auto_in_a_bits_mask,
  input  logic [63:0] auto_in_a_bits_data,
  input  logic        auto_in_a_bits_corrupt,
  input  logic        auto_out_a_ready,
  output logic        auto_out_a_valid,
  output logic [2:0]  auto_out_a_bits_opcode,
  output logic [2:0]  auto_out_a_bits_param,
  output logic [2:0]  auto_out_a_bits_size,
  output logic [2:0]  auto_out_a_bits_source,
  output logic [30:0] auto_out_a_bits_address,
  output logic [7:0]  auto_out_a_bits_mask,
  output logic [63:0] auto_out_a_bits_data,
  output logic        auto_out_a_bits_corrupt,
  output logic        auto_out_d_ready,
  input  logic        auto_out_d_valid,
  input  logic [2:0]  auto_out_d_bits_opcode,
  input  logic [2:0]  auto_out_d_bits_size,
  input  logic [2:0]  auto_out_d_bits_source,
  input  logic [63:0] auto_out_d_bits_data,
  input  logic        auto_in_d_ready,
  output logic        auto_in_d_valid,
  output logic [2:0]  auto_in_d_bits_opcode,
  output logic [2:0]  auto_in_d_bits_size,
  output logic [2:0]  auto_in_d_bits_source,
  output logic [63:0] auto_in_d_bits_data,
  output logic [3:0]  a_count,
  output logic [3:0]  d_count
);
  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [2:0]  source;
    logic [30:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic        corrupt;
  } a_beat_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  size;
    logic [2:0]  source;
    logic [63:0] data;
  } d_beat_t;

  a_beat_t a_in_dat, a_out_dat;
  d_beat_t d_in_dat, d_out_dat;

  assign a_in_dat = '{
    opcode:  auto_in_a_bits_opcode,
    param:   auto_in_a_bits_param,
    size:    auto_in_a_bits_size,
    source:  auto_in_a_bits_source,
    address: auto_in_a_bits_address,
    mask:    auto_in_a_bits_mask,
    data:    auto_in_a_bits_data,
    corrupt: auto_in_a_bits_corrupt
  };

  assign d_in_dat = '{
    opcode: auto_out_d_bits_opcode,
    size:   auto_out_d_bits_size,
    source: auto_out_d_bits_source,
    data:   auto_out_d_bits_data
  };

  tl_buffer_ad_fifo #(.DEPTH(A_DEPTH), .W($bits(a_beat_t))) u_a_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (auto_in_a_valid),
    .in_rdy  (auto_in_a_ready),
    .in_dat  (a_in_dat),
    .out_vld (auto_out_a_valid),
    .out_rdy (auto_out_a_ready),
    .out_dat (a_out_dat),
    .count   (a_count)
  );

  tl_buffer_ad_fifo #(.DEPTH(D_DEPTH), .W($bits(d_beat_t))) u_d_fifo (
    .clock   (clock),
    .reset   (reset),
    .in_vld  (auto_out_d_valid),
    .in_rdy  (auto_out_d_ready),
    .in_dat  (d_in_dat),
    .out_vld (auto_in_d_valid),
    .out_rdy (auto_in_d_ready),
    .out_dat (d_out_dat),
    .count   (d_count)
  );

  assign auto_out_a_bits_opcode  = a_out_dat.opcode;
  assign auto_out_a_bits_param   = a_out_dat.param;
  assign auto_out_a_bits_size    = a_out_dat.size;
  assign auto_out_a_bits_source  = a_out_dat.source;
  assign auto_out_a_bits_address = a_out_dat.address;
  assign auto_out_a_bits_mask    = a_out_dat.mask;
  assign auto_out_a_bits_data    = a_out_dat.data;
  assign auto_out_a_bits_corrupt = a_out_dat.corrupt;

  assign auto_in_d_bits_opcode = d_out_dat.opcode;
  assign auto_in_d_bits_size   = d_out_dat.size;
  assign auto_in_d_bits_source = d_out_dat.source;
  assign auto_in_d_bits_data   = d_out_dat.data;
endmodule

// File: doc/tl_buffer_ad.md
# tl_buffer_ad

Registered TileLink-UL buffer for the A and D channels, placed between a TileLink master port and the single-slave crossbar. It decouples timing on both directions with independent circular FIFOs: A requests move master to slave, D responses move slave to master. Every field passes through unmodified. Occupancy counts are exported for the bus monitor and for performance counters.

## Interface
Parameters:
- `A_DEPTH`, default 2: A-channel FIFO entries, legal range 1..8, need not be a power of two.
- `D_DEPTH`, default 2: D-channel FIFO entries, legal range 1..8.

Ports:
- `clock`  in  1  single clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `auto_in_a_ready`  out  1  A FIFO can accept.
- `auto_in_a_valid`  in  1  master A request valid.
- `auto_in_a_bits_opcode` / `_param` / `_size` / `_source`  in  3 each  A fields.
- `auto_in_a_bits_address`  in  31  A address.
- `auto_in_a_bits_mask`  in  8  byte mask.
- `auto_in_a_bits_data`  in  64  write data.
- `auto_in_a_bits_corrupt`  in  1  corrupt flag.
- `auto_out_a_*`  out  same names and widths as `auto_in_a_*` (valid and bits); `auto_out_a_ready` is an input.
- `auto_out_d_ready`  out  1  D FIFO can accept.
- `auto_out_d_valid`  in  1  slave D response valid.
- `auto_out_d_bits_opcode` / `_size` / `_source`  in  3 each  D fields.
- `auto_out_d_bits_data`  in  64  read data.
- `auto_in_d_*`  out  same names and widths as `auto_out_d_*` (valid and bits); `auto_in_d_ready` is an input.
- `a_count`  out  4  A FIFO occupancy.
- `d_count`  out  4  D FIFO occupancy.

## Operation
- The two FIFOs are identical and fully independent. Each FIFO holds:
  - storage array,
  - read pointer `rptr` and write pointer `wptr`,
  - occupancy `count` in the range 0..DEPTH.
- Enqueue fires on `in valid & ready`. The beat is written at `wptr`; `wptr` then advances.
- Dequeue fires on `out valid & ready`. `rptr` then advances.
- Pointer wrap is explicit: at DEPTH-1 the pointer goes to 0. Arithmetic is not modulo 2^n.
- `count` update:
  - +1 on enqueue only,
  - -1 on dequeue only,
  - unchanged on both or neither.
- Accept ready = `count != DEPTH`. Ready does not depend on the same-cycle dequeue, so there is no combinational ready path.
- Output valid = `count != 0`. Output bits = storage[`rptr`].
- Full with a dequeue in the same cycle: ready is still low; no enqueue; count becomes DEPTH-1.
- Empty: a beat written this cycle is visible on the outputs next cycle.
- FIFOs are strictly in order. No field is inspected or altered; no beat is dropped or duplicated.
- `a_count` and `d_count` equal the registered counts, zero-extended to 4 bits.

## Timing
- Reset (asynchronous assertion, synchronous release) clears:
  - pointers, counts and storage to 0;
  - every output to 0, including both readies.
- While `reset` is high, readies are forced to 0 combinationally.
- First accept is possible in the first cycle after `reset` deasserts.
- Latency is 1 cycle from input handshake to output valid.
- Throughput is 1 beat/cycle when DEPTH >= 2. With DEPTH = 1 it is 1 beat per 2 cycles.
- Reset asserted mid-transfer discards all buffered beats immediately. Upstream must also reset.
- Output valid and bits are stable while valid is high and ready is low.

## Configuration
- `TL_BUFFER_FLOW_EN`:
  - **Defined:** a FIFO that is empty and has input valid drives the input bits straight to its outputs with valid=1, in the same cycle.
    - If the output ready is also 1, the beat passes through and is not stored; count stays 0.
    - Otherwise the beat is enqueued.
    - Latency is 0 when empty.
  - **Undefined:** no bypass path exists; latency is always 1 cycle.

## Test plan
- **Reset:** assert `reset` mid-clock with 2 beats buffered -> all outputs 0 immediately; `a_count` = 0; readies 0 until deassert, then 1.
- **Single read:** A beat (opcode 4, source 5, address 0x1000_0000) -> appears on `auto_out_a` 1 cycle later with identical fields; `a_count` pulses 1.
- **Back-pressure fill:** hold `auto_out_a_ready` = 0 and present 3 beats -> first 2 accepted; `auto_in_a_ready` = 0 with `a_count` = 2. Release ready -> beats exit in order, 2 cycles back-to-back.
- **Streaming:** both readies high with 100 consecutive A beats and D beats (data = index) -> 1 beat/cycle each direction, order preserved, no loss.
- **Wrap:** A_DEPTH = 3 with 10 random-stall beats -> pointers wrap 2 -> 0; data matches the scoreboard.
- **Flow option:** with `TL_BUFFER_FLOW_EN`, empty D FIFO and `auto_in_d_ready` = 1 -> D beat (data 0xDEADBEEF) visible the same cycle and `d_count` stays 0. Without the macro -> visible the next cycle.
